// File: rtl/alu_arbiter_if.sv
// rtl/alu_arbiter_if.sv - request, ALU and response bus shared by alu_arbiter and its neighbours
interface alu_arbiter_if #(
    parameter int XLEN = 32
);
    // Requester port 0
    logic            req0_valid;
    logic            req0_ready;
    logic [2:0]      req0_funct3;
    logic            req0_funct7_5;
    logic [XLEN-1:0] req0_i1;
    logic [XLEN-1:0] req0_i2;

    // Requester port 1
    logic            req1_valid;
    logic            req1_ready;
    logic [2:0]      req1_funct3;
    logic            req1_funct7_5;
    logic [XLEN-1:0] req1_i1;
    logic [XLEN-1:0] req1_i2;

    // Shared ALU
    logic [2:0]      alu_funct3;
    logic            alu_funct7_5;
    logic [XLEN-1:0] alu_i1;
    logic [XLEN-1:0] alu_i2;
    logic [XLEN-1:0] alu_out;

    // Response register
    logic            rsp_valid;
    logic            rsp_ready;
    logic            rsp_id;
    logic [XLEN-1:0] rsp_data;

    // Arbiter side
    modport slave (
        input  req0_valid, req0_funct3, req0_funct7_5, req0_i1, req0_i2,
        output req0_ready,
        input  req1_valid, req1_funct3, req1_funct7_5, req1_i1, req1_i2,
        output req1_ready,
        output alu_funct3, alu_funct7_5, alu_i1, alu_i2,
        input  alu_out,
        output rsp_valid, rsp_id, rsp_data,
        input  rsp_ready
    );

    // Requesters, ALU and response consumer side
    modport master (
        output req0_valid, req0_funct3, req0_funct7_5, req0_i1, req0_i2,
        input  req0_ready,
        output req1_valid, req1_funct3, req1_funct7_5, req1_i1, req1_i2,
        input  req1_ready,
        input  alu_funct3, alu_funct7_5, alu_i1, alu_i2,
        output alu_out,
        input  rsp_valid, rsp_id, rsp_data,
        output rsp_ready
    );
endinterface

// File: rtl/alu_arbiter.sv
// rtl/alu_arbiter.sv - two-port arbiter for one registered ALU; ALU_ARB_RR_EN selects round-robin over fixed priority
module alu_arbiter #(
    parameter int XLEN = 32
) (
    input  logic          clk,
    input  logic          rst,
    alu_arbiter_if.slave  bus
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        HOLD = 2'd2
    } state_t;

    state_t          state_q, state_d;
    logic            inflight_id_q, inflight_id_d;
    logic            rsp_valid_q, rsp_valid_d;
    logic            rsp_id_q, rsp_id_d;
    logic [XLEN-1:0] rsp_data_q, rsp_data_d;
`ifdef ALU_ARB_RR_EN
    logic            last_q, last_d;
`endif

    logic            issue;
    logic            grant0;
    logic            grant1;
    logic [2:0]      alu_funct3;
    logic            alu_funct7_5;
    logic [XLEN-1:0] alu_i1;
    logic [XLEN-1:0] alu_i2;

    // Pick at most one winner while the ALU slot is free (idle, or held result being drained)
    always_comb begin
        issue = !rst && ((state_q == IDLE) || ((state_q == HOLD) && bus.rsp_ready));
`ifdef ALU_ARB_RR_EN
        // On conflict the port that did not win last time goes first
        grant1 = issue && bus.req1_valid && (!bus.req0_valid || !last_q);
        grant0 = issue && bus.req0_valid && !grant1;
`else
        // Port 0 always wins a conflict; port 1 only gets idle slots
        grant0 = issue && bus.req0_valid;
        grant1 = issue && bus.req1_valid && !bus.req0_valid;
`endif
    end

    // Steer the winner's operation onto the ALU; zeros when nothing is granted
    always_comb begin
        alu_funct3   = 3'b000;
        alu_funct7_5 = 1'b0;
        alu_i1       = '0;
        alu_i2       = '0;
        if (grant0) begin
            alu_funct3   = bus.req0_funct3;
            alu_funct7_5 = bus.req0_funct7_5;
            alu_i1       = bus.req0_i1;
            alu_i2       = bus.req0_i2;
        end else if (grant1) begin
            alu_funct3   = bus.req1_funct3;
            alu_funct7_5 = bus.req1_funct7_5;
            alu_i1       = bus.req1_i1;
            alu_i2       = bus.req1_i2;
        end
    end

    // Next-state logic: grant -> EXEC, capture ALU result -> HOLD, drain -> IDLE or re-issue
    always_comb begin
        state_d       = state_q;
        inflight_id_d = inflight_id_q;
        rsp_valid_d   = rsp_valid_q;
        rsp_id_d      = rsp_id_q;
        rsp_data_d    = rsp_data_q;
`ifdef ALU_ARB_RR_EN
        last_d        = last_q;
        if (grant0 || grant1) begin
            last_d = grant1;
        end
`endif
        case (state_q)
            IDLE: begin
                if (grant0 || grant1) begin
                    state_d       = EXEC;
                    inflight_id_d = grant1;
                end
            end
            EXEC: begin
                // The registered ALU output now reflects the granted operands
                rsp_data_d  = bus.alu_out;
                rsp_id_d    = inflight_id_q;
                rsp_valid_d = 1'b1;
                state_d     = HOLD;
            end
            HOLD: begin
                if (bus.rsp_ready) begin
                    rsp_valid_d = 1'b0;
                    if (grant0 || grant1) begin
                        state_d       = EXEC;
                        inflight_id_d = grant1;
                    end else begin
                        state_d = IDLE;
                    end
                end
            end
            default: begin
                state_d     = IDLE;
                rsp_valid_d = 1'b0;
            end
        endcase
    end

    // State and response registers; reset drops any in-flight or held result
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= IDLE;
            inflight_id_q <= 1'b0;
            rsp_valid_q   <= 1'b0;
            rsp_id_q      <= 1'b0;
            rsp_data_q    <= '0;
`ifdef ALU_ARB_RR_EN
            last_q        <= 1'b1;
`endif
        end else begin
            state_q       <= state_d;
            inflight_id_q <= inflight_id_d;
            rsp_valid_q   <= rsp_valid_d;
            rsp_id_q      <= rsp_id_d;
            rsp_data_q    <= rsp_data_d;
`ifdef ALU_ARB_RR_EN
            last_q        <= last_d;
`endif
        end
    end

    assign bus.req0_ready   = grant0;
    assign bus.req1_ready   = grant1;
    assign bus.alu_funct3   = alu_funct3;
    assign bus.alu_funct7_5 = alu_funct7_5;
    assign bus.alu_i1       = alu_i1;
    assign bus.alu_i2       = alu_i2;
    assign bus.rsp_valid    = rsp_valid_q;
    assign bus.rsp_id       = rsp_id_q;
    assign bus.rsp_data     = rsp_data_q;

endmodule

// File: tb/tb_alu_arbiter.sv
// tb/tb_alu_arbiter.sv - scoreboard bench for alu_arbiter with a registered ALU model
module tb_alu_arbiter;

    localparam int XLEN = 32;
`ifdef ALU_ARB_RR_EN
    localparam bit RR = 1'b1;
`else
    localparam bit RR = 1'b0;
`endif

    logic clk;
    logic rst;
    int   cyc;
    int   checks;
    int   failures;
    logic [32:0] sb[$];

    alu_arbiter_if #(.XLEN(XLEN)) bus ();

    alu_arbiter #(.XLEN(XLEN)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Registered ALU model
    function automatic logic [31:0] alu_fn(input logic [2:0] f3, input logic f75,
                                           input logic [31:0] a, input logic [31:0] b);
        case (f3)
            3'b000:  return f75 ? a - b : a + b;
            3'b001:  return a << b[4:0];
            3'b010:  return {31'd0, $signed(a) < $signed(b)};
            3'b011:  return {31'd0, a < b};
            3'b100:  return a ^ b;
            3'b101:  return f75 ? 32'($signed(a) >>> b[4:0]) : a >> b[4:0];
            3'b110:  return a | b;
            default: return a & b;
        endcase
    endfunction

    always @(posedge clk) bus.alu_out <= alu_fn(bus.alu_funct3, bus.alu_funct7_5, bus.alu_i1, bus.alu_i2);

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%08h expected 0x%08h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Monitor: consumes responses on handshake and compares against the scoreboard
    always @(negedge clk) begin
        logic [32:0] e;
        #2;
        if (!rst && bus.rsp_valid && bus.rsp_ready) begin
            if (sb.size() == 0) begin
                chk("unexpected_rsp", 32'd1, 32'd0);
            end else begin
                e = sb.pop_front();
                chk("rsp_id", {31'd0, bus.rsp_id}, {31'd0, e[32]});
                chk("rsp_data", bus.rsp_data, e[31:0]);
            end
        end
    end

    task automatic set_req(input int p, input logic v, input logic [2:0] f3, input logic f75,
                           input logic [31:0] a, input logic [31:0] b);
        if (p == 0) begin
            bus.req0_valid = v; bus.req0_funct3 = f3; bus.req0_funct7_5 = f75;
            bus.req0_i1 = a; bus.req0_i2 = b;
        end else begin
            bus.req1_valid = v; bus.req1_funct3 = f3; bus.req1_funct7_5 = f75;
            bus.req1_i1 = a; bus.req1_i2 = b;
        end
    endtask

    // Called at a falling edge; checks this cycle first, then later cycles, bounded
    task automatic wait_grant(output int who, output int at);
        who = -1;
        at  = -1;
        for (int i = 0; i < 20; i++) begin
            #1;
            if (bus.req0_ready || bus.req1_ready) begin
                chk("grant_onehot", {31'd0, bus.req0_ready & bus.req1_ready}, 32'd0);
                who = bus.req1_ready ? 1 : 0;
                at  = cyc;
                break;
            end
            @(negedge clk);
        end
        if (who < 0) chk("grant_timeout", 32'd1, 32'd0);
    endtask

    task automatic do_op(input int p, input logic [2:0] f3, input logic f75,
                         input logic [31:0] a, input logic [31:0] b, input logic [31:0] exp);
        int who, at;
        @(negedge clk);
        set_req(p, 1'b1, f3, f75, a, b);
        wait_grant(who, at);
        chk("grant_port", 32'(who), 32'(p));
        chk("alu_i1", bus.alu_i1, a);
        chk("alu_i2", bus.alu_i2, b);
        chk("alu_funct", {28'd0, bus.alu_funct7_5, bus.alu_funct3}, {28'd0, f75, f3});
        sb.push_back({p[0], exp});
        @(posedge clk);
        #1;
        set_req(p, 1'b0, 3'b000, 1'b0, 32'd0, 32'd0);
    endtask

    initial begin
        int who, at, prev, c0, exp_w;
        checks = 0; failures = 0; cyc = 0;
        rst = 1'b1;
        bus.rsp_ready = 1'b0;
        bus.alu_out = '0;
        set_req(0, 1'b1, 3'b110, 1'b1, 32'h1234, 32'h5678);
        set_req(1, 1'b1, 3'b111, 1'b1, 32'h9abc, 32'hdef0);

        // Reset values; grants and ALU drive suppressed while reset is held
        repeat (3) @(negedge clk);
        #1;
        chk("rst_ready0", {31'd0, bus.req0_ready}, 32'd0);
        chk("rst_ready1", {31'd0, bus.req1_ready}, 32'd0);
        chk("rst_alu_i1", bus.alu_i1, 32'd0);
        chk("rst_alu_f3", {29'd0, bus.alu_funct3}, 32'd0);
        chk("rst_rsp_valid", {31'd0, bus.rsp_valid}, 32'd0);
        chk("rst_rsp_id", {31'd0, bus.rsp_id}, 32'd0);
        chk("rst_rsp_data", bus.rsp_data, 32'd0);
        set_req(0, 1'b0, 3'b000, 1'b0, 32'd0, 32'd0);
        set_req(1, 1'b0, 3'b000, 1'b0, 32'd0, 32'd0);
        rst = 1'b0;

        // Single ADD 5+7: response at grant+2, held while rsp_ready is low
        @(negedge clk);
        set_req(0, 1'b1, 3'b000, 1'b0, 32'd5, 32'd7);
        wait_grant(who, at);
        chk("t1_grant", 32'(who), 32'd0);
        sb.push_back({1'b0, 32'd12});
        @(posedge clk);
        #1;
        set_req(0, 1'b0, 3'b000, 1'b0, 32'd0, 32'd0);
        @(negedge clk);
        #1;
        chk("t1_valid_t1", {31'd0, bus.rsp_valid}, 32'd0);
        @(negedge clk);
        #1;
        chk("t1_latency", 32'(cyc - at), 32'd2);
        chk("t1_valid_t2", {31'd0, bus.rsp_valid}, 32'd1);
        chk("t1_id", {31'd0, bus.rsp_id}, 32'd0);
        chk("t1_data", bus.rsp_data, 32'd12);
        repeat (3) begin
            @(negedge clk);
            #1;
            chk("t1_hold_valid", {31'd0, bus.rsp_valid}, 32'd1);
            chk("t1_hold_data", bus.rsp_data, 32'd12);
        end
        @(negedge clk);
        bus.rsp_ready = 1'b1;

        // SUB and SRA through port 1
        do_op(1, 3'b000, 1'b1, 32'd3, 32'd5, 32'hFFFF_FFFE);
        do_op(1, 3'b101, 1'b1, 32'h8000_0000, 32'd4, 32'hF800_0000);
        repeat (3) @(negedge clk);

        // Back-pressure with both ports waiting
        bus.rsp_ready = 1'b0;
        do_op(0, 3'b100, 1'b0, 32'hFF, 32'h0F, 32'hF0);
        @(negedge clk);
        set_req(0, 1'b1, 3'b110, 1'b0, 32'd1, 32'd2);
        set_req(1, 1'b1, 3'b000, 1'b0, 32'd2, 32'd2);
        #1;
        chk("bp_exec_noready", {30'd0, bus.req1_ready, bus.req0_ready}, 32'd0);
        repeat (5) begin
            @(negedge clk);
            #1;
            chk("bp_hold_noready", {30'd0, bus.req1_ready, bus.req0_ready}, 32'd0);
            chk("bp_hold_valid", {31'd0, bus.rsp_valid}, 32'd1);
            chk("bp_hold_data", bus.rsp_data, 32'hF0);
        end
        @(negedge clk);
        c0 = cyc;
        bus.rsp_ready = 1'b1;
        wait_grant(who, at);
        chk("bp_same_cycle", 32'(at), 32'(c0));
        exp_w = RR ? 1 : 0;
        chk("bp_winner", 32'(who), 32'(exp_w));
        sb.push_back(exp_w == 0 ? {1'b0, 32'd3} : {1'b1, 32'd4});
        @(posedge clk);
        #1;
        set_req(exp_w, 1'b0, 3'b000, 1'b0, 32'd0, 32'd0);
        @(negedge clk);
        wait_grant(who, at);
        chk("bp_second", 32'(who), 32'(1 - exp_w));
        sb.push_back(exp_w == 0 ? {1'b1, 32'd4} : {1'b0, 32'd3});
        @(posedge clk);
        #1;
        set_req(1 - exp_w, 1'b0, 3'b000, 1'b0, 32'd0, 32'd0);
        repeat (4) @(negedge clk);

        // Conflict from reset: both continuously valid
        rst = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        set_req(0, 1'b1, 3'b000, 1'b0, 32'd10, 32'd1);
        set_req(1, 1'b1, 3'b000, 1'b1, 32'd10, 32'd1);
        prev = -1;
        for (int k = 0; k < 4; k++) begin
            wait_grant(who, at);
            exp_w = RR ? (k % 2) : 0;
            chk("cf_winner", 32'(who), 32'(exp_w));
            if (k > 0) chk("cf_spacing", 32'(at - prev), 32'd2);
            sb.push_back(exp_w == 0 ? {1'b0, 32'd11} : {1'b1, 32'd9});
            prev = at;
            if (k < 3) @(negedge clk);
        end
        @(posedge clk);
        #1;
        set_req(0, 1'b0, 3'b000, 1'b0, 32'd0, 32'd0);
        set_req(1, 1'b0, 3'b000, 1'b0, 32'd0, 32'd0);
        repeat (4) @(negedge clk);

        // Reset during EXEC discards the result
        set_req(0, 1'b1, 3'b000, 1'b0, 32'd1, 32'd1);
        wait_grant(who, at);
        chk("rm_grant", 32'(who), 32'd0);
        @(posedge clk);
        #1;
        rst = 1'b1;
        set_req(0, 1'b1, 3'b000, 1'b0, 32'd5, 32'd6);
        @(negedge clk);
        #1;
        chk("rm_ready_in_rst", {31'd0, bus.req0_ready}, 32'd0);
        chk("rm_alu_i1_in_rst", bus.alu_i1, 32'd0);
        @(negedge clk);
        set_req(0, 1'b0, 3'b000, 1'b0, 32'd0, 32'd0);
        rst = 1'b0;
        repeat (3) begin
            @(negedge clk);
            #1;
            chk("rm_no_rsp", {31'd0, bus.rsp_valid}, 32'd0);
        end
        do_op(0, 3'b111, 1'b0, 32'h0000_F0F0, 32'h0000_FF00, 32'h0000_F000);
        repeat (4) @(negedge clk);
        chk("sb_empty", 32'(sb.size()), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
